// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - edge-captured, maskable, fixed-priority interrupt controller
//
// Purpose: captures rising edges on irq_in into a pending register, gates them
// through an enable mask and presents the highest-numbered eligible source on a
// valid/ready handshake. One source is presented at a time, and its id is frozen
// until the consumer acknowledges it.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       synchronous active-low reset
//   irq_in      per-source level request lines
//   mask_we     mask write strobe
//   mask_wdata  new enable mask (bit set = enabled)
//   irq_valid   a source is presented on irq_id
//   irq_id      index of the presented source
//   irq_ready   consumer acknowledge (takes effect only while irq_valid)
//   pending     current pending register
//   mask        current enable mask register
module interrupt_controller #(
  parameter int NUM_SOURCES = 16,
  parameter int ID_WIDTH    = $clog2(NUM_SOURCES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SOURCES-1:0] irq_in,
  input  logic                   mask_we,
  input  logic [NUM_SOURCES-1:0] mask_wdata,
  output logic                   irq_valid,
  output logic [ID_WIDTH-1:0]    irq_id,
  input  logic                   irq_ready,
  output logic [NUM_SOURCES-1:0] pending,
  output logic [NUM_SOURCES-1:0] mask
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [NUM_SOURCES-1:0] irq_prev;
  logic [NUM_SOURCES-1:0] rise;
  logic [NUM_SOURCES-1:0] eligible;
  logic [NUM_SOURCES-1:0] ack_clr;
  logic [NUM_SOURCES-1:0] pending_next;
  logic [ID_WIDTH-1:0]    sel_id;
  logic [ID_WIDTH-1:0]    id_next;
  logic                   ack;

  assign rise     = irq_in & ~irq_prev;
  assign eligible = pending & mask;
  assign ack      = (state == PRESENT) && irq_ready;
  assign ack_clr  = ack ? (NUM_SOURCES'(1) << irq_id) : '0;
  // A new edge on the source being acknowledged is applied after the clear,
  // so the fresh request survives and is presented again later.
  assign pending_next = (pending & ~ack_clr) | rise;

  // irq_valid is a pure decode of the state register.
  assign irq_valid = (state == PRESENT);

  // Ascending scan: the last hit is the highest eligible index.
  always_comb begin
    sel_id = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (eligible[i]) begin
        sel_id = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_next = state;
    id_next    = irq_id;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_next = PRESENT;
          id_next    = sel_id;
        end
      end
      PRESENT: begin
        // irq_id holds regardless of mask/pending changes until acknowledged.
        if (irq_ready) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      irq_id   <= '0;
      pending  <= '0;
      mask     <= '0;
      irq_prev <= '0;
    end else begin
      state    <= state_next;
      irq_id   <= id_next;
      pending  <= pending_next;
      irq_prev <= irq_in;
      if (mask_we) begin
        mask <= mask_wdata;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - self-checking bench for interrupt_controller
module tb_interrupt_controller;
  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  irq_in;
  logic          mask_we;
  logic [N-1:0]  mask_wdata;
  logic          irq_valid;
  logic [IW-1:0] irq_id;
  logic          irq_ready;
  logic [N-1:0]  pending;
  logic [N-1:0]  mask;

  int checks   = 0;
  int failures = 0;

  // Reference model state: what the spec says the registers should hold.
  logic [N-1:0] m_pend;
  logic [N-1:0] m_mask;
  logic [N-1:0] m_prev;
  bit           m_valid;
  int           m_id;

  interrupt_controller #(.NUM_SOURCES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ready (irq_ready),
    .pending   (pending),
    .mask      (mask)
  );

  always #5 clk = ~clk;

  // Apply the spec's rules for one clock edge, using the inputs currently driven.
  function automatic void model_edge();
    int  best;
    bit  acked;
    if (!rst_n) begin
      m_pend = '0; m_mask = '0; m_prev = '0; m_valid = 0; m_id = 0;
      return;
    end
    acked = m_valid && irq_ready;
    best  = -1;
    if (!m_valid) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (m_pend[i] && m_mask[i]) begin best = i; break; end
      end
    end
    if (acked) m_pend[m_id] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (irq_in[i] && !m_prev[i]) m_pend[i] = 1'b1;
      m_prev[i] = irq_in[i];
    end
    if (mask_we) m_mask = mask_wdata;
    if (acked) m_valid = 0;
    else if (!m_valid && best >= 0) begin m_valid = 1; m_id = best; end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; irq_ready = 1'b0;
    tick(); tick();
    checks++; if (pending !== 16'h0) begin failures++; $display("FAIL reset_pending got=%h exp=%h", pending, 16'h0); end
    checks++; if (mask !== 16'h0) begin failures++; $display("FAIL reset_mask got=%h exp=%h", mask, 16'h0); end
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", irq_valid); end
    checks++; if (irq_id !== 4'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
    rst_n = 1'b1;
    tick();
    checks++; if (pending !== 16'h0) begin failures++; $display("FAIL post_reset_pending got=%h exp=0", pending); end
  endtask

  task automatic test_single();
    mask_we = 1'b1; mask_wdata = 16'hFFFF;
    tick();
    mask_we = 1'b0;
    checks++; if (mask !== 16'hFFFF) begin failures++; $display("FAIL single_mask got=%h exp=ffff", mask); end
    irq_in = 16'h0020;
    tick();
    irq_in = '0;
    checks++; if (pending !== 16'h0020) begin failures++; $display("FAIL single_pend_e0 got=%h exp=0020", pending); end
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL single_valid_e0 got=%b exp=0", irq_valid); end
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd5) begin failures++; $display("FAIL single_present got=%b/%0d exp=1/5", irq_valid, irq_id); end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checks++; if (pending !== 16'h0 || irq_valid !== 1'b0) begin failures++; $display("FAIL single_ack got=%h/%b exp=0000/0", pending, irq_valid); end
  endtask

  task automatic test_priority();
    int order [3] = '{12, 9, 3};
    irq_in = 16'h1208;
    tick();
    irq_in = '0;
    checks++; if (pending !== 16'h1208) begin failures++; $display("FAIL prio_pending got=%h exp=1208", pending); end
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (irq_valid !== 1'b1 || irq_id !== 4'(order[k])) begin failures++; $display("FAIL prio_order_%0d got=%b/%0d exp=1/%0d", k, irq_valid, irq_id, order[k]); end
      irq_ready = 1'b1;
      tick();
      irq_ready = 1'b0;
      checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL prio_gap_%0d got=%b exp=0", k, irq_valid); end
      tick();
    end
    checks++; if (pending !== 16'h0 || irq_valid !== 1'b0) begin failures++; $display("FAIL prio_end got=%h/%b exp=0000/0", pending, irq_valid); end
  endtask

  task automatic test_mask_gate();
    mask_we = 1'b1; mask_wdata = 16'h0000;
    tick();
    mask_we = 1'b0; irq_in = 16'h0080;
    tick();
    irq_in = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (irq_valid !== 1'b0 || pending !== 16'h0080) begin failures++; $display("FAIL gate_masked_%0d got=%b/%h exp=0/0080", k, irq_valid, pending); end
    end
    mask_we = 1'b1; mask_wdata = 16'h0080;
    tick();
    mask_we = 1'b0;
    checks++; if (mask !== 16'h0080 || irq_valid !== 1'b0) begin failures++; $display("FAIL gate_write got=%h/%b exp=0080/0", mask, irq_valid); end
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd7) begin failures++; $display("FAIL gate_present got=%b/%0d exp=1/7", irq_valid, irq_id); end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checks++; if (pending !== 16'h0) begin failures++; $display("FAIL gate_ack got=%h exp=0000", pending); end
  endtask

  task automatic test_hold();
    mask_we = 1'b1; mask_wdata = 16'hFFFF;
    tick();
    mask_we = 1'b0; irq_in = 16'h0010;
    tick();
    irq_in = '0;
    tick();
    for (int k = 0; k < 10; k++) begin
      if (k == 2) irq_in = 16'h8000;
      mask_we = (k == 5); mask_wdata = 16'h0000;
      tick();
      checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd4) begin failures++; $display("FAIL hold_%0d got=%b/%0d exp=1/4", k, irq_valid, irq_id); end
    end
    mask_we = 1'b0; irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    tick();
    checks++; if (irq_valid !== 1'b0 || pending !== 16'h8000 || mask !== 16'h0) begin failures++; $display("FAIL hold_after got=%b/%h/%h exp=0/8000/0000", irq_valid, pending, mask); end
    irq_in = '0; mask_we = 1'b1; mask_wdata = 16'hFFFF;
    tick();
    mask_we = 1'b0;
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd15) begin failures++; $display("FAIL hold_src15 got=%b/%0d exp=1/15", irq_valid, irq_id); end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
  endtask

  task automatic test_ack_collision();
    irq_in = 16'h0004;
    tick();
    irq_in = '0;
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd2) begin failures++; $display("FAIL coll_present got=%b/%0d exp=1/2", irq_valid, irq_id); end
    irq_in = 16'h0004; irq_ready = 1'b1;
    tick();
    irq_in = '0; irq_ready = 1'b0;
    checks++; if (pending !== 16'h0004 || irq_valid !== 1'b0) begin failures++; $display("FAIL coll_setwins got=%h/%b exp=0004/0", pending, irq_valid); end
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd2) begin failures++; $display("FAIL coll_represent got=%b/%0d exp=1/2", irq_valid, irq_id); end
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checks++; if (pending !== 16'h0) begin failures++; $display("FAIL coll_clear got=%h exp=0000", pending); end
  endtask

  task automatic test_reset_mid();
    irq_in = 16'h0002;
    tick();
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd1) begin failures++; $display("FAIL rmid_present got=%b/%0d exp=1/1", irq_valid, irq_id); end
    rst_n = 1'b0; irq_ready = 1'b1; mask_we = 1'b1; mask_wdata = 16'hFFFF;
    tick();
    irq_ready = 1'b0; mask_we = 1'b0;
    checks++; if (pending !== 16'h0 || mask !== 16'h0 || irq_valid !== 1'b0 || irq_id !== 4'd0) begin failures++; $display("FAIL rmid_zero got=%h/%h/%b/%0d exp=0000/0000/0/0", pending, mask, irq_valid, irq_id); end
    rst_n = 1'b1;
    tick();
    checks++; if (pending !== 16'h0002) begin failures++; $display("FAIL rmid_recapture got=%h exp=0002", pending); end
    tick(); tick();
    checks++; if (irq_valid !== 1'b0) begin failures++; $display("FAIL rmid_masked got=%b exp=0", irq_valid); end
    mask_we = 1'b1; mask_wdata = 16'hFFFF;
    tick();
    mask_we = 1'b0;
    tick();
    checks++; if (irq_valid !== 1'b1 || irq_id !== 4'd1) begin failures++; $display("FAIL rmid_after_mask got=%b/%0d exp=1/1", irq_valid, irq_id); end
    irq_in = '0; irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int k = 0; k < 600; k++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      irq_in     = N'($urandom & $urandom & $urandom);
      mask_we    = ($urandom_range(0, 7) == 0);
      mask_wdata = N'($urandom);
      irq_ready  = $urandom_range(0, 1);
      tick();
      checks++;
      if (pending !== m_pend || mask !== m_mask || irq_valid !== m_valid || (m_valid && irq_id !== 4'(m_id))) begin
        failures++;
        if (bad < 10) $display("FAIL rand_%0d got=%h/%h/%b/%0d exp=%h/%h/%b/%0d", k, pending, mask, irq_valid, irq_id, m_pend, m_mask, m_valid, m_id);
        bad++;
      end
    end
    rst_n = 1'b1; irq_in = '0; mask_we = 1'b0; irq_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask_gate();
    test_hold();
    test_ack_collision();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
